seg7_bin_display: RTL

Sequential binary-to-decimal seven-segment driver, parametrised in input width, digit count, signedness and segment polarity. Latches a binary value on a start handshake and converts it iteratively with double-dabble, one bit per cycle. Outputs registered segment patterns with leading-zero blanking, a minus sign and overflow indication. Sits between datapath results (e.g. the four-function calculator ALU) and the board HEX displays.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_digit_enc.sv | 28 ++
 rtl/seg7_bin_display.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants for the binary-to-decimal seven-segment driver.
//            Segment patterns are active-high, bit order g,f,e,d,c,b,a.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-high segment patterns for decimal digits 0..9
    localparam logic [6:0] c_SEG_DIGIT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [6:0] c_SEG_BLANK = 7'b0000000;
    localparam logic [6:0] c_SEG_DASH  = 7'b1000000;

    // Converter sequencing states
    localparam int         c_STATE_W   = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_UPDATE = 2'd2;

    // BCD nibbles needed for any WIDTH-bit magnitude (log10(2) ~ 0.301)
    function automatic int bcd_nibbles(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_enc.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit_enc
// Purpose  : One digit of BCD-to-seven-segment decoding (active-high).
//            Dash wins over blank, blank wins over the digit value.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    // Select dash, blank or the decimal glyph; non-decimal codes stay dark
    always_comb begin
        o_seg = c_SEG_BLANK;
        if (i_dash) begin
            o_seg = c_SEG_DASH;
        end else if (!i_blank && (i_bcd <= 4'd9)) begin
            o_seg = c_SEG_DIGIT[i_bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_bin_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_bin_display
// Purpose  : Latches a binary value on start, converts it to BCD with
//            double-dabble (one bit per cycle) and registers seven-segment
//            patterns with leading-zero blanking, minus sign and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_bin_display
    import seg7_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 6,
    parameter int SIGNED         = 0,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int c_NB = bcd_nibbles(WIDTH);
    localparam int c_BW = 4 * c_NB;
    localparam int c_CW = $clog2(WIDTH + 1);
    localparam int c_HW = 7 * DIGITS;
    localparam logic [c_HW-1:0] c_HEX_OFF = (SEG_ACTIVE_LOW != 0) ? {c_HW{1'b1}} : {c_HW{1'b0}};

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_stateNext;
    logic                 r_sign;
    logic [WIDTH-1:0]     r_mag;
    logic [c_BW-1:0]      r_bcd;
    logic [c_CW-1:0]      r_cnt;
    logic [c_HW-1:0]      r_hex;
    logic                 r_ovf;
    logic                 r_done;

    logic                 w_negIn;
    logic [WIDTH-1:0]     w_magIn;
    logic [c_BW-1:0]      w_bcdAdj;
    int                   w_sigCnt;
    logic                 w_ovf;
    logic [DIGITS-1:0]    w_blank;
    logic [DIGITS-1:0]    w_dash;
    logic [c_HW-1:0]      w_seg;

    // Sign and magnitude of the incoming value; the most negative value
    // negates to itself, which reads correctly as an unsigned magnitude
    assign w_negIn = (SIGNED != 0) && value[WIDTH-1];
    assign w_magIn = w_negIn ? -value : value;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: accept start only when idle, run WIDTH shifts, then publish
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_stateNext = c_ST_SHIFT;
            c_ST_SHIFT:  if (r_cnt == c_CW'(1)) w_stateNext = c_ST_UPDATE;
            c_ST_UPDATE: w_stateNext = c_ST_IDLE;
            default:     w_stateNext = c_ST_IDLE;
        endcase
    end

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int k = 0; k < c_NB; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: latch operand, then shift one bit per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_sign <= w_negIn;
                        r_mag  <= w_magIn;
                        r_bcd  <= '0;
                        r_cnt  <= c_CW'(WIDTH);
                    end
                end
                c_ST_SHIFT: begin
                    // The bit leaving the top nibble is always zero since
                    // c_NB covers the full magnitude range
                    r_bcd <= c_BW'({w_bcdAdj, r_mag[WIDTH-1]});
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - c_CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Digit layout: significant count, overflow, sign position and blanking
    always_comb begin
        w_sigCnt = 1;
        w_ovf    = 1'b0;
        w_blank  = '0;
        w_dash   = '0;
        for (int k = 0; k < c_NB; k++) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                w_sigCnt = k + 1;
                if (k >= DIGITS) w_ovf = 1'b1;
            end
        end
        if ((w_sigCnt + int'(r_sign)) > DIGITS) w_ovf = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ovf) begin
                w_dash[i] = 1'b1;
            end else if (i >= w_sigCnt) begin
                if (r_sign && ((BLANK_LZ != 0) ? (i == w_sigCnt) : (i == DIGITS - 1))) begin
                    w_dash[i] = 1'b1;
                end else if (BLANK_LZ != 0) begin
                    w_blank[i] = 1'b1;
                end
            end
        end
    end

    // One encoder per displayed digit; positions beyond the BCD register read as 0
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_nib;
        if (i < c_NB) begin : g_nib
            assign w_nib = r_bcd[4*i +: 4];
        end else begin : g_pad
            assign w_nib = 4'd0;
        end
        seg7_digit_enc u_enc (
            .i_bcd   (w_nib),
            .i_blank (w_blank[i]),
            .i_dash  (w_dash[i]),
            .o_seg   (w_seg[7*i +: 7])
        );
    end

    // Output registers change only when a conversion completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex  <= c_HEX_OFF;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_ST_UPDATE);
            if (r_state == c_ST_UPDATE) begin
                r_hex <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
                r_ovf <= w_ovf;
            end
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign hex  = r_hex;

endmodule
`default_nettype wire
